// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, the per-cycle
// control bundle, and the rule set applied whenever the pipeline may advance.
package pipe_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2,
    HALT      = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        flush_if_id;
    logic        flush_id_ex;
    pipe_state_t next;
    logic        wait_clear;
  } pipe_ctrl_t;

  // Priority: memory stall > taken branch > load-use. A taken branch squashes
  // the dependent instruction, so a concurrent load-use needs no bubble.
  function automatic pipe_ctrl_t run_rules(input logic mem_stall,
                                           input logic branch,
                                           input logic load_use);
    pipe_ctrl_t c;
    c      = '0;
    c.next = RUN;
    if (mem_stall) begin
      c.next       = MEM_WAIT;
      c.wait_clear = 1'b1;
    end else if (branch) begin
      {c.pc_en, c.if_id_en, c.id_ex_en, c.ex_mem_en, c.mem_wb_en} = 5'b11111;
      c.flush_if_id = 1'b1;
      c.flush_id_ex = 1'b1;
    end else if (load_use) begin
      {c.id_ex_en, c.ex_mem_en, c.mem_wb_en} = 3'b111;
      c.flush_id_ex = 1'b1;
      c.next        = LU_BUBBLE;
    end else begin
      {c.pc_en, c.if_id_en, c.id_ex_en, c.ex_mem_en, c.mem_wb_en} = 5'b11111;
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM_WAIT cycles; expired flags the last cycle allowed before halting.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so the count never wraps while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != W'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard/stall sequencer for a 5-stage pipeline. Define PIPE_PERF_EN to build
// the stall_cycles / flush_events performance counters; otherwise they read 0.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic        load_use,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [1:0]  state_o,
  output logic        err_o,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  pipe_state_t state_q, state_d;
  pipe_ctrl_t  ctrl;
  logic        err_q;
  logic        timer_en;
  logic        expired;
  logic        set_err;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctrl.wait_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    ctrl      = '0;
    ctrl.next = state_q;
    timer_en  = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      RUN:       ctrl = run_rules(mem_req && !mem_ready, branch_taken, load_use);
      LU_BUBBLE: ctrl = run_rules(mem_req && !mem_ready, branch_taken, 1'b0);
      MEM_WAIT: begin
        // Completion cycle is an ordinary advance cycle, hazards included.
        if (mem_ready) begin
          ctrl = run_rules(1'b0, branch_taken, load_use);
        end else begin
          timer_en = 1'b1;
          if (expired) begin
            ctrl.next = HALT;
            set_err   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    state_d = ctrl.next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_err) err_q <= 1'b1;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign flush_if_id = ctrl.flush_if_id;
  assign flush_id_ex = ctrl.flush_id_ex;
  assign state_o     = state_q;
  assign err_o       = err_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, ~ctrl.pc_en};
    flush_events_d = flush_events_q + {31'd0, ctrl.flush_if_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (MEM_TIMEOUT=4).
module tb_pipeline_sequencer;

  localparam int TO = 4;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        branch_taken = 1'b0, load_use = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        flush_if_id, flush_id_ex, err_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles, flush_events;

  pipeline_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .load_use     (load_use),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .state_o      (state_o),
    .err_o        (err_o),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  // observed vector: {state, err, pc, if_id, id_ex, ex_mem, mem_wb, fl_if_id, fl_id_ex, stall, flush}
  logic [73:0] obs;
  assign obs = {state_o, err_o, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                flush_if_id, flush_id_ex, stall_cycles, flush_events};

  // scoreboard
  logic [73:0] exp_q[$];
  logic [73:0] exp_v;
  int total = 0;
  int bad   = 0;

  // reference model state
  logic [1:0]  m_state = 2'd0;
  int          m_cnt   = 0;
  logic        m_err   = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  // Drives one cycle at the falling edge, pushes the expected outputs for it and
  // advances the model across the coming rising edge.
  task automatic drive_cycle(input bit r, input bit br, input bit lu,
                             input bit req, input bit rdy);
    logic [4:0] en;
    logic       fa, fb;
    logic [1:0] nxt;
    bit         clr;
    @(negedge clk);
    rst = r; branch_taken = br; load_use = lu; mem_req = req; mem_ready = rdy;
    en = 5'b00000; fa = 1'b0; fb = 1'b0; nxt = m_state; clr = 1'b0;
    if (m_state == 2'd3 || (m_state == 2'd2 && !rdy)) begin
      en = 5'b00000;
    end else if (req && !rdy) begin
      nxt = 2'd2; clr = 1'b1;
    end else if (br) begin
      en = 5'b11111; fa = 1'b1; fb = 1'b1; nxt = 2'd0;
    end else if (lu && m_state != 2'd1) begin
      en = 5'b00111; fb = 1'b1; nxt = 2'd1;
    end else begin
      en = 5'b11111; nxt = 2'd0;
    end
    exp_q.push_back({m_state, m_err, en, fa, fb,
                     PERF ? m_stall : 32'd0, PERF ? m_flush : 32'd0});
    if (r) begin
      m_state = 2'd0; m_cnt = 0; m_err = 1'b0; m_stall = '0; m_flush = '0;
    end else begin
      m_stall = m_stall + (en[4] ? 32'd0 : 32'd1);
      m_flush = m_flush + (fa ? 32'd1 : 32'd0);
      if (m_state == 2'd2 && !rdy) begin
        if (m_cnt == TO - 1) begin
          nxt = 2'd3; m_err = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (clr) m_cnt = 0;
      m_state = nxt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    m_state = 2'd0; m_cnt = 0; m_err = 1'b0; m_stall = '0; m_flush = '0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 0, 0, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 0, 0, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, i < 2, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL load_use cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_branch_lu();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, i == 0, i == 0, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL branch_lu cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  // {br, lu, req, rdy} per step: mem wait resolved with branch, then with load-use,
  // then a memory stall raised from LU_BUBBLE.
  task automatic test_mem_wait();
    logic [3:0] stim[14];
    stim = '{4'b0010, 4'b0010, 4'b0010, 4'b1011, 4'b0000,
             4'b0010, 4'b0011 | 4'b0100, 4'b0000, 4'b0000,
             4'b0100, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
    for (int i = 0; i < 14; i++) begin
      drive_cycle(0, stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL mem_wait cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 12; i++) begin
      // 8 stalled cycles, 2 cycles of ignored inputs in HALT, reset, then load-use
      if (i < 8)       drive_cycle(0, 0, 0, 1, 0);
      else if (i < 10) drive_cycle(0, 1, 1, 1, 1);
      else if (i == 10) drive_cycle(1, 0, 0, 1, 0);
      else             drive_cycle(0, 0, 1, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_midwait();
    for (int i = 0; i < 6; i++) begin
      if (i < 3)       drive_cycle(0, 0, 0, 1, 0);
      else if (i == 3) drive_cycle(1, 0, 0, 1, 0);
      else             drive_cycle(0, 0, i == 4, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL reset_midwait cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    bit r;
    for (int i = 0; i < 300; i++) begin
      r = (m_state == 2'd3) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      drive_cycle(r, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_wrap();
    drive_cycle(1, 0, 0, 0, 0);
    #1; void'(exp_q.pop_front());
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    m_stall = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, i == 0, 0, 0);
      #1; exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_midwait();
    test_random();
`ifdef PIPE_PERF_EN
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles before halting.
REQ-002 SHALL have ports clk (input, 1): single clock, all state on rising edge.
REQ-003 SHALL have ports rst (input, 1): synchronous, active-high reset.
REQ-004 SHALL have port branch_taken (input, 1): taken branch/jump resolved in EX.
REQ-005 SHALL have port load_use (input, 1): ID instruction depends on load in EX.
REQ-006 SHALL have ports mem_req (input, 1) and mem_ready (input, 1): MEM-stage access request and completion.
REQ-007 SHALL have outputs pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en (1 each): stage register enables.
REQ-008 SHALL have outputs flush_if_id, flush_id_ex (1 each): bubble insertion into the IF/ID and ID/EX registers.
REQ-009 SHALL have output state_o (2): current FSM state; err_o (1): sticky timeout flag.
REQ-010 SHALL have outputs stall_cycles (32) and flush_events (32): performance counters.

Function
REQ-011 SHALL implement FSM states RUN=0, LU_BUBBLE=1, MEM_WAIT=2, HALT=3.
REQ-012 SHALL evaluate "RUN rules" with priority memory stall > branch > load-use; memory stall is mem_req && !mem_ready.
REQ-013 RUN rules, memory stall: all enables 0, flushes 0, next state MEM_WAIT, wait counter cleared.
REQ-014 RUN rules, branch_taken (no memory stall): all enables 1, flush_if_id=1, flush_id_ex=1, next state RUN; any concurrent load_use is discarded.
REQ-015 RUN rules, load_use only: pc_en=0, if_id_en=0, flush_id_ex=1, other enables 1, next state LU_BUBBLE.
REQ-016 RUN rules, no event: all enables 1, flushes 0, next state RUN.
REQ-017 LU_BUBBLE SHALL apply RUN rules with load_use masked to 0; it therefore inserts exactly one bubble per load-use.
REQ-018 MEM_WAIT with mem_ready=0 SHALL drive all enables 0 and flushes 0, and increment the wait counter.
REQ-019 MEM_WAIT with mem_ready=1 SHALL apply RUN rules in that same cycle, including branch and load-use; the next state is taken from those rules.
REQ-020 MEM_WAIT SHALL go to HALT when the counter equals MEM_TIMEOUT-1 and mem_ready=0; err_o is set on that edge.
REQ-021 HALT SHALL drive all enables 0 and flushes 0, ignore all inputs, and be left only by rst.
REQ-022 SHALL keep all outputs combinational from state plus inputs, giving zero-cycle stall/flush latency; state_o SHALL be registered.
REQ-023 SHALL size the wait counter $clog2(MEM_TIMEOUT+1) bits, with no wrap inside MEM_WAIT.

Reset
REQ-024 rst SHALL set state RUN, the wait counter 0, err_o 0, and both perf counters 0 on the next rising edge.
REQ-025 rst asserted mid-MEM_WAIT or in HALT SHALL abandon the wait; the following cycle follows RUN rules.

Configuration
REQ-026 With macro PIPE_PERF_EN defined: stall_cycles SHALL increment on every cycle with pc_en=0, and flush_events on every cycle with flush_if_id=1; both are 32-bit and wrap modulo 2^32.
REQ-027 Without PIPE_PERF_EN: stall_cycles and flush_events SHALL remain as ports, tied to 0, with no counter flops inferred.

Structure
REQ-028 SHALL place the state enum typedef (pipe_state_t) and the default MEM_TIMEOUT constant in package pipe_ctrl_pkg.
REQ-029 SHALL implement the wait counter and timeout compare as sub-module mem_wait_timer (inputs clear/enable; output expired).

Verification
REQ-030 Idle, no events, 10 cycles -> all enables 1, flushes 0, state_o=0, counters 0.
REQ-031 load_use held high for 2 cycles -> cycle 1: pc_en=0, flush_id_ex=1; cycle 2 (LU_BUBBLE): all enables 1, no flush; stall_cycles=1.
REQ-032 branch_taken and load_use in the same cycle -> flush_if_id=flush_id_ex=1, pc_en=1, next state RUN, flush_events=1.
REQ-033 mem_req=1, mem_ready low for 3 cycles then high together with branch_taken -> 3 cycles all enables 0 (state 2), then a flush cycle with enables 1, then state RUN; stall_cycles=3.
REQ-034 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 forever -> state 3 after cycle 4, err_o=1, enables stay 0; rst -> state 0, err_o 0.
REQ-035 Preload stall_cycles to 32'hFFFF_FFFF via a forced stall run -> one more stall cycle yields 0; build without PIPE_PERF_EN -> both counters read 0 throughout.
